// File: rtl/spi_page_buf.sv
// rtl/spi_page_buf.sv - page-data source (RAM / pattern / fill) streaming over valid/ready
module spi_page_buf #(
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] PAGE_LEN = (ADDR_W+1)'(PAGE_BYTES);

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem [PAGE_BYTES];
  logic [DATA_W-1:0]   rd_data_q;

  logic                fire;
  logic                is_last;
  logic [DATA_W-1:0]   src_byte;
  logic [ADDR_W:0]     len_eff;

  // Source mux and handshake; data is forced to zero whenever nothing is presented
  always_comb begin
    fire     = (state_q == S_STREAM) && out_ready;
    is_last  = (idx_q == (len_q - 1'b1));
    case (mode_q)
      2'd1:    src_byte = seed_q + DATA_W'(idx_q);
      2'd2:    src_byte = seed_q;
      default: src_byte = rd_data_q;
    endcase
    out_valid = (state_q == S_STREAM);
    out_data  = out_valid ? src_byte : '0;
    out_last  = out_valid && is_last;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    checksum  = checksum_q;
    if ((len == '0) || (len > PAGE_LEN)) len_eff = PAGE_LEN;
    else                                 len_eff = len;
  end

  // Next-state logic; abort wins over a coincident fire so that byte is never counted
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          seed_d     = seed;
          addr_d     = start_addr;
          len_d      = len_eff;
          idx_d      = '0;
          checksum_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_STREAM;
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fire) begin
          checksum_d = checksum_q + out_data;
          if (is_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      seed_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
    end
  end

  // Page RAM: host writes only when idle; read port tracks the next address so data is ready after a fire
  always_ff @(posedge sys_clk) begin
    if (wr_en && (state_q == S_IDLE)) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[addr_d];
  end

endmodule
